// File: rtl/conv_ctrl_pkg.sv
// Shared constants for the convolution accelerator control slave:
// register word indices, CTRL/STATUS bit positions, ID value and AXI responses.
package conv_ctrl_pkg;

  typedef enum logic [2:0] {
    REG_CTRL     = 3'd0,
    REG_STATUS   = 3'd1,
    REG_IMG_BASE = 3'd2,
    REG_OUT_BASE = 3'd3,
    REG_CYCLES   = 3'd4,
    REG_ID       = 3'd5
  } reg_idx_e;

  localparam logic [4:0] OFS_CTRL     = 5'h00;
  localparam logic [4:0] OFS_STATUS   = 5'h04;
  localparam logic [4:0] OFS_IMG_BASE = 5'h08;
  localparam logic [4:0] OFS_OUT_BASE = 5'h0C;
  localparam logic [4:0] OFS_CYCLES   = 5'h10;
  localparam logic [4:0] OFS_ID       = 5'h14;

  localparam int CTRL_START    = 0;
  localparam int CTRL_SOFT_RST = 1;
  localparam int CTRL_IRQ_EN   = 2;

  localparam int STAT_DONE = 0;
  localparam int STAT_BUSY = 1;
  localparam int STAT_ERR  = 2;

  localparam logic [31:0] CONV_ID = 32'h434E5632;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_conv_ctrl_if.sv
// AXI4-Lite bus bundle for the convolution control slave; the master modport
// is the bus side (CPU/bench), the slave modport is this block.
interface axi_conv_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi_lite_slave_if.sv
// AXI4-Lite handshake engine: latches AW and W independently, issues one
// wr_en pulse once both are held, and serves reads with one cycle of latency.
module axi_lite_slave_if
  import conv_ctrl_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                s_axi_aclk,
  input  logic                s_axi_aresetn,
  axi_conv_ctrl_if.slave      s_axi,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [DATA_W-1:0]   wr_data,
  output logic [DATA_W/8-1:0] wr_strb,
  input  logic                wr_err,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [DATA_W-1:0]   rd_data,
  input  logic                rd_err
);

  logic                aw_held;
  logic                w_held;
  logic                aw_hs;
  logic                w_hs;
  logic [ADDR_W-1:0]   aw_addr_p0;
  logic [DATA_W-1:0]   w_data_p0;
  logic [DATA_W/8-1:0] w_strb_p0;
  logic                unused_prot;

  assign aw_hs   = s_axi.awvalid & s_axi.awready;
  assign w_hs    = s_axi.wvalid & s_axi.wready;
  assign wr_en   = aw_held & w_held;
  assign wr_addr = aw_addr_p0;
  assign wr_data = w_data_p0;
  assign wr_strb = w_strb_p0;
  assign rd_en   = s_axi.arvalid & s_axi.arready;
  assign rd_addr = s_axi.araddr;
  assign unused_prot = &{1'b0, s_axi.awprot, s_axi.arprot};

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      s_axi.awready <= 1'b0;
      s_axi.wready  <= 1'b0;
      s_axi.bvalid  <= 1'b0;
      s_axi.bresp   <= RESP_OKAY;
      s_axi.arready <= 1'b0;
      s_axi.rvalid  <= 1'b0;
      s_axi.rresp   <= RESP_OKAY;
      s_axi.rdata   <= '0;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
    end else begin
      // Ready pulses only while the channel is empty and no response is outstanding.
      s_axi.awready <= s_axi.awvalid & ~s_axi.awready & ~aw_held & ~s_axi.bvalid;
      s_axi.wready  <= s_axi.wvalid & ~s_axi.wready & ~w_held & ~s_axi.bvalid;
      if (aw_hs) aw_held <= 1'b1;
      if (w_hs)  w_held  <= 1'b1;

      if (wr_en) begin
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
        s_axi.bvalid <= 1'b1;
        s_axi.bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axi.bvalid && s_axi.bready) begin
        s_axi.bvalid <= 1'b0;
      end

      s_axi.arready <= s_axi.arvalid & ~s_axi.arready & ~s_axi.rvalid;
      if (rd_en) begin
        s_axi.rvalid <= 1'b1;
        s_axi.rdata  <= rd_data;
        s_axi.rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axi.rvalid && s_axi.rready) begin
        s_axi.rvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (aw_hs) aw_addr_p0 <= s_axi.awaddr;
    if (w_hs) begin
      w_data_p0 <= s_axi.wdata;
      w_strb_p0 <= s_axi.wstrb;
    end
  end

endmodule

// File: rtl/axi_conv_ctrl.sv
// Control/status register block for the convolution accelerator.
// Optional CYCLES busy counter is built when CONV_CTRL_PERF_CNT_EN is defined.
module axi_conv_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int IMG_ADDR_W         = 11,
  parameter int OUT_ADDR_W         = 13
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  axi_conv_ctrl_if.slave        s_axi,
  output logic                  accel_start,
  output logic                  accel_soft_rst,
  output logic [IMG_ADDR_W-1:0] img_base,
  output logic [OUT_ADDR_W-1:0] out_base,
  input  logic                  accel_busy,
  input  logic                  accel_done,
  output logic                  irq
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;

  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [DW/8-1:0] wr_strb;
  logic            wr_err;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;
  logic [DW-1:0]   rd_data;
  logic            rd_err;

  reg_idx_e wr_idx;
  reg_idx_e rd_idx;

  logic irq_en;
  logic sta_done;
  logic sta_err;
  logic [31:0] cycles;

  logic ctrl_wr;
  logic soft_req;
  logic start_req;
  logic launch;
  logic start_err;
  logic done_clr;
  logic err_clr;
  logic [IMG_ADDR_W-1:0] img_nxt;
  logic [OUT_ADDR_W-1:0] out_nxt;
  logic unused_ok;

  axi_lite_slave_if #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) u_slave (
    .s_axi_aclk    (s_axi_aclk),
    .s_axi_aresetn (s_axi_aresetn),
    .s_axi         (s_axi),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_strb       (wr_strb),
    .wr_err        (wr_err),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_err        (rd_err)
  );

  assign wr_idx    = reg_idx_e'(wr_addr[4:2]);
  assign rd_idx    = reg_idx_e'(rd_addr[4:2]);
  assign wr_err    = (wr_addr[4:3] == 2'b11);
  assign unused_ok = &{1'b0, rd_en, wr_addr, rd_addr, wr_data, wr_strb};

  // START while the core is busy, or while the previous pulse is still in flight, is an error.
  always_comb begin
    ctrl_wr   = wr_en && (wr_idx == REG_CTRL) && wr_strb[0];
    soft_req  = ctrl_wr && wr_data[CTRL_SOFT_RST];
    start_req = ctrl_wr && wr_data[CTRL_START] && !soft_req;
    launch    = start_req && !accel_busy && !accel_start;
    start_err = start_req && !launch;
    done_clr  = wr_en && (wr_idx == REG_STATUS) && wr_strb[0] && wr_data[STAT_DONE];
    err_clr   = wr_en && (wr_idx == REG_STATUS) && wr_strb[0] && wr_data[STAT_ERR];
  end

  always_comb begin
    img_nxt = img_base;
    out_nxt = out_base;
    for (int i = 0; i < IMG_ADDR_W; i++)
      if (wr_strb[i/8]) img_nxt[i] = wr_data[i];
    for (int i = 0; i < OUT_ADDR_W; i++)
      if (wr_strb[i/8]) out_nxt[i] = wr_data[i];
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      accel_start    <= 1'b0;
      accel_soft_rst <= 1'b0;
      irq_en         <= 1'b0;
      sta_done       <= 1'b0;
      sta_err        <= 1'b0;
      img_base       <= '0;
      out_base       <= '0;
      irq            <= 1'b0;
    end else begin
      accel_start    <= launch;
      accel_soft_rst <= soft_req;
      if (ctrl_wr) irq_en <= wr_data[CTRL_IRQ_EN];

      // Hardware set beats software clear in the same cycle.
      if (soft_req)        sta_done <= 1'b0;
      else if (accel_done) sta_done <= 1'b1;
      else if (done_clr)   sta_done <= 1'b0;

      if (soft_req)       sta_err <= 1'b0;
      else if (start_err) sta_err <= 1'b1;
      else if (err_clr)   sta_err <= 1'b0;

      if (wr_en && wr_idx == REG_IMG_BASE) img_base <= img_nxt;
      if (wr_en && wr_idx == REG_OUT_BASE) out_base <= out_nxt;
      irq <= irq_en & sta_done;
    end
  end

`ifdef CONV_CTRL_PERF_CNT_EN
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn)               cycles <= '0;
    else if (soft_req || launch)      cycles <= '0;
    else if (accel_busy && cycles != 32'hFFFF_FFFF) cycles <= cycles + 32'd1;
  end
`else
  assign cycles = '0;
`endif

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    case (rd_idx)
      REG_CTRL:     rd_data[CTRL_IRQ_EN] = irq_en;
      REG_STATUS: begin
        rd_data[STAT_DONE] = sta_done;
        rd_data[STAT_BUSY] = accel_busy;
        rd_data[STAT_ERR]  = sta_err;
      end
      REG_IMG_BASE: rd_data[IMG_ADDR_W-1:0] = img_base;
      REG_OUT_BASE: rd_data[OUT_ADDR_W-1:0] = out_base;
      REG_CYCLES:   rd_data = cycles;
      REG_ID:       rd_data = CONV_ID;
      default:      rd_err  = 1'b1;
    endcase
  end

endmodule

// File: doc/axi_conv_ctrl.md
# axi_conv_ctrl

AXI4-Lite control/status slave for the convolution accelerator, successor to the first-generation wrapper. Independent AW/W acceptance, byte strobes, sticky W1C status, busy-protected start, soft reset, interrupt, and programmable BRAM base addresses. The accelerator core and its BRAM ports stay outside; this block drives only the control side.

## Interface
- C_S_AXI_DATA_WIDTH, 32, AXI data width (only 32 supported)
- C_S_AXI_ADDR_WIDTH, 5, AXI byte address width (8 word slots)
- IMG_ADDR_W, 11, width of image BRAM base address
- OUT_ADDR_W, 13, width of output BRAM base address
- s_axi_aclk  in  1  clock; all logic on rising edge
- s_axi_aresetn  in  1  reset, synchronous, active-low
- s_axi_aw*/w*/b*/ar*/r*  AXI4-Lite slave channels, standard widths; awprot/arprot ignored
- accel_start  out  1  one-cycle start pulse
- accel_soft_rst  out  1  one-cycle soft-reset pulse to core
- img_base  out  IMG_ADDR_W  image read base address
- out_base  out  OUT_ADDR_W  output write base address
- accel_busy  in  1  core running
- accel_done  in  1  one-cycle completion pulse
- irq  out  1  level interrupt

## Operation
- Register map (byte offset): 0x00 CTRL, 0x04 STATUS, 0x08 IMG_BASE, 0x0C OUT_BASE, 0x10 CYCLES, 0x14 ID (0x434E5632), 0x18/0x1C unmapped.
- CTRL: bit0 START (self-clearing, reads 0), bit1 SOFT_RST (self-clearing, reads 0), bit2 IRQ_EN (R/W).
- STATUS: bit0 DONE (sticky, W1C), bit1 BUSY (live accel_busy, RO), bit2 ERR (sticky, W1C; set by START while busy).
- IMG_BASE/OUT_BASE: R/W, low IMG_ADDR_W/OUT_ADDR_W bits stored, upper bits read 0; drive img_base/out_base directly.
- Writes honour s_axi_wstrb per byte; ID and CYCLES writes ignored, OKAY.
- START=1 with accel_busy=0: accel_start pulses next cycle. With accel_busy=1 or START pending: no pulse, ERR set.
- SOFT_RST=1: accel_soft_rst pulses; clears DONE, ERR, CYCLES; IRQ_EN and bases kept. If START and SOFT_RST in same write, SOFT_RST wins, no start.
- accel_done in same cycle as W1C of DONE: set wins (DONE stays 1).
- irq = IRQ_EN & DONE, registered.
- Unmapped address: write discarded, bresp=SLVERR; read rdata=0, rresp=SLVERR.

## Timing
- Reset values: all ready/valid low, bresp/rresp OKAY, rdata 0, accel_start/accel_soft_rst/irq 0, img_base/out_base 0, all registers 0.
- Write: awready/wready each pulse one cycle when their channel is valid and not already latched; AW and W may arrive in any order/cycle. Register update on the cycle after both latched; bvalid asserted same cycle, held until bready; no new AW/W accepted while bvalid high.
- Read: arready pulses one cycle on arvalid when rvalid low; rvalid+rdata the following cycle, held stable until rready.
- Read and write may overlap; a read of STATUS on the cycle a write clears it returns pre-write value.
- accel_start rises exactly 1 cycle after bvalid-rising write cycle… i.e. same edge as register update; width exactly 1.
- Reset asserted mid-transaction: transaction dropped, all outputs to reset values next edge.

## Configuration
- CONV_CTRL_PERF_CNT_EN defined: CYCLES is a 32-bit counter, cleared on accel_start, incremented each cycle accel_busy=1, saturates at 0xFFFFFFFF.
- Undefined: no counter logic; CYCLES reads 0.

## Structure
- Package conv_ctrl_pkg: register offset constants, CTRL/STATUS bit indices, ID constant, RESP_OKAY/RESP_SLVERR.
- One sub-module natural: axi_lite_slave_if (AW/W/B/AR/R handshakes, presents wr_en/wr_addr/wr_data/wr_strb and rd_en/rd_addr/rd_data/rd_err); register file and control logic in axi_conv_ctrl.

## Test plan
- Reset, read 0x14 -> 0x434E5632 OKAY; read 0x04 -> 0.
- Write W before AW (3-cycle gap) 0x08=0x7FF, strb 0xF -> one bvalid OKAY, img_base=0x7FF; write 0x0C=0xFFFF_FFFF strb 0x1 -> out_base=0x0FF.
- Write CTRL=0x5, busy=0 -> one accel_start pulse; done pulse -> STATUS=0x1, irq=1; write STATUS=0x1 -> STATUS=0, irq=0.
- busy=1, write CTRL=0x1 -> no accel_start, STATUS=0x6; write CTRL=0x2 -> accel_soft_rst pulse, ERR cleared.
- Read 0x18 -> rdata 0, rresp=SLVERR; write 0x1C -> bresp=SLVERR, no state change.
- With macro: busy held 100 cycles after start -> CYCLES=100; without macro -> CYCLES=0.
